mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one word-wide unified main memory between the instruction cache and the data cache, replacing the two private memories. An I-cache 128-bit block refill is split into four sequential 32-bit memory reads. D-cache word accesses pass through unchanged. Simultaneous requests are granted round-robin. The block sits between both cache controllers and the single memory; the CPU stalls on the OR of the two cache busy lines as before.

## Interface
- No parameters. Constants are in the package.
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IREAD  in  1  I-cache block read request, held until IBUSY falls.
- IADDRESS  in  6  I-cache block address.
- IREADDATA  out  128  assembled block. Beat k maps to bits [32k+31:32k].
- IBUSY  out  1  I-cache stall.
- DREAD, DWRITE  in  1 each  D-cache word read/write, held until DBUSY falls.
- DADDRESS  in  6  D-cache block (word) address.
- DWRITEDATA  in  32  write-back data.
- DREADDATA  out  32  read data.
- DBUSY  out  1  D-cache stall.
- MREAD, MWRITE  out  1 each  memory request.
- MADDRESS  out  9  word address. D region = {3'b000,DADDRESS}. I region = 9'h100 + {IADDRESS,beat[1:0]}.
- MWRITEDATA  out  32  memory write data.
- MREADDATA  in  32  memory read data.
- MBUSY  in  1  memory busy.

## Operation
- States:
  - IDLE
  - D_ACC
  - I_BEAT
  - I_GAP
  - DONE_I
  - DONE_D
- IDLE:
  - If only one side requests, grant it.
  - If both request, grant the side not granted last. The `last` flag resets to D, so I wins the first tie after reset.
  - On grant, register MADDRESS, MWRITEDATA and MREAD/MWRITE. Clear `seen_busy`.
  - Go to D_ACC, or to I_BEAT with beat=0.
- Memory completion: a rising edge where the request is high, MBUSY=0 and `seen_busy`=1. `seen_busy` is set on any edge with MBUSY=1.
- D_ACC completion:
  - Drop MREAD/MWRITE.
  - On a read, capture MREADDATA into DREADDATA.
  - Go to DONE_D.
- I_BEAT completion:
  - Capture the beat into IREADDATA.
  - Drop MREAD.
  - If beat=3, go to DONE_I. Otherwise go to I_GAP.
- I_GAP: beat+1, re-issue MREAD with the new address, clear `seen_busy`, return to I_BEAT. Beat is a 2-bit counter; it wraps to 0 only via IDLE.
- DONE_x: busy of that side is low for exactly this cycle, then go to IDLE and toggle `last`.
- IBUSY = IREAD && state!=DONE_I. DBUSY = (DREAD||DWRITE) && state!=DONE_D. Both are combinational.
- DREAD and DWRITE high together is illegal; the block treats it as a write.
- Requests are not retractable. A granted transaction always completes.
- Data outputs hold their last value until overwritten.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, last=D, beat=0.
  - MREAD=MWRITE=0, MADDRESS=0, MWRITEDATA=0, IREADDATA=0, DREADDATA=0.
  - IBUSY/DBUSY follow the combinational rule throughout reset.
- Reset in mid-transaction aborts it. Memory sees its request drop immediately; partial I data is discarded.
- Grant latency: memory request is high on the first edge after the cache request is seen in IDLE.
- D access: 1 (grant) + L (memory) + 1 (DONE) cycles, where L counts edges from issue to completion.
- I refill: 1 + 4L + 3 (gaps) + 1 cycles.
- A request arriving in DONE_x or from the other side waits in IDLE for its turn. A waiting requester is served before the same side is served twice.

## Structure
- Package mem_arb_pkg holds:
  - the state enum;
  - I_BASE=9'h100;
  - BEATS=4;
  - the owner encoding for `last`.
- No sub-module; beat assembly and round-robin are inline.
- Top-level wiring:
  - the existing data_memory is replaced by a 512×32 unified memory with the same busy protocol;
  - the instruction memory is removed.

## Test plan
- D read alone:
  - Setup: memory latency 5, word 0x0F holds 0xA5A5A5A5.
  - Stimulus: DREAD with DADDRESS=0x0F.
  - Required: MADDRESS=0x00F; DREADDATA=0xA5A5A5A5; DBUSY low 1 cycle after completion.
- I refill:
  - Stimulus: IREAD with IADDRESS=0x02.
  - Required: reads 0x108, 0x109, 0x10A, 0x10B in order with one MREAD-low gap cycle between each; IREADDATA assembles beat 0 into bits [31:0].
- Tie after reset:
  - Stimulus: IREAD and DWRITE in the same cycle.
  - Required: I is served first, then D. A second tie is served D first.
- D write:
  - Stimulus: DWRITE with DADDRESS=0x3F, DWRITEDATA=0xDEADBEEF.
  - Required: MWRITE high with MADDRESS=0x03F; word 0x03F reads back 0xDEADBEEF.
- Reset asserted during beat 2 of a refill:
  - Required: MREAD falls immediately and IREADDATA=0.
  - After reset release: IREAD still high restarts at beat 0.
- No starvation:
  - Stimulus: D requests back-to-back while IREAD is held.
  - Required: I is granted after at most one D transaction.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter between the I-cache and D-cache.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_ACC  = 3'd1,
        I_BEAT = 3'd2,
        I_GAP  = 3'd3,
        DONE_I = 3'd4,
        DONE_D = 3'd5
    } arb_state_e;

    // Records which side was granted most recently, for round-robin tie breaking.
    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } owner_e;

    localparam logic [8:0] I_BASE    = 9'h100;
    localparam int         BEATS     = 4;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    function automatic logic [8:0] i_word_addr(input logic [5:0] blk, input logic [1:0] beat);
        return I_BASE + {1'b0, blk, beat};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and unified-memory signals seen by the arbiter.
interface mem_arbiter_if;
    // Request/busy handshake: a requester raises its request and holds it (and its
    // address/data) until its busy line is low for one cycle; memory requests
    // complete on an edge with MBUSY low after MBUSY has been seen high.
    logic         iread;
    logic [5:0]   iaddress;
    logic [127:0] ireaddata;
    logic         ibusy;

    logic         dread;
    logic         dwrite;
    logic [5:0]   daddress;
    logic [31:0]  dwritedata;
    logic [31:0]  dreaddata;
    logic         dbusy;

    logic         mread;
    logic         mwrite;
    logic [8:0]   maddress;
    logic [31:0]  mwritedata;
    logic [31:0]  mreaddata;
    logic         mbusy;

    modport slave (
        input  iread, iaddress, dread, dwrite, daddress, dwritedata, mreaddata, mbusy,
        output ireaddata, ibusy, dreaddata, dbusy, mread, mwrite, maddress, mwritedata
    );

    modport master (
        output iread, iaddress, dread, dwrite, daddress, dwritedata, mreaddata, mbusy,
        input  ireaddata, ibusy, dreaddata, dbusy, mread, mwrite, maddress, mwritedata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory between the I-cache (4-beat block
// refills) and the D-cache (single-word reads and writes).
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus,
    output arb_state_e   dbg_state
);

    arb_state_e state;
    owner_e     last;
    logic [1:0] beat;
    logic       seen_busy;

    logic d_req;
    logic i_req;
    logic grant_i;
    logic mem_done;

    assign d_req    = bus.dread | bus.dwrite;
    assign i_req    = bus.iread;
    assign grant_i  = i_req & (~d_req | (last == OWN_D));
    assign mem_done = (bus.mread | bus.mwrite) & ~bus.mbusy & seen_busy;

    assign bus.ibusy = i_req & (state != DONE_I);
    assign bus.dbusy = d_req & (state != DONE_D);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last           <= OWN_D;
            beat           <= 2'd0;
            seen_busy      <= 1'b0;
            bus.mread      <= 1'b0;
            bus.mwrite     <= 1'b0;
            bus.maddress   <= 9'd0;
            bus.mwritedata <= 32'd0;
            bus.ireaddata  <= 128'd0;
            bus.dreaddata  <= 32'd0;
        end else begin
            seen_busy <= seen_busy | bus.mbusy;
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        bus.mread    <= 1'b1;
                        bus.mwrite   <= 1'b0;
                        bus.maddress <= i_word_addr(bus.iaddress, 2'd0);
                        beat         <= 2'd0;
                        seen_busy    <= 1'b0;
                        state        <= I_BEAT;
                    end else if (d_req) begin
                        // Both strobes high is treated as a write.
                        bus.mread      <= ~bus.dwrite;
                        bus.mwrite     <= bus.dwrite;
                        bus.maddress   <= {3'b000, bus.daddress};
                        bus.mwritedata <= bus.dwritedata;
                        seen_busy      <= 1'b0;
                        state          <= D_ACC;
                    end
                end
                D_ACC: begin
                    if (mem_done) begin
                        if (bus.mread) begin
                            bus.dreaddata <= bus.mreaddata;
                        end
                        bus.mread  <= 1'b0;
                        bus.mwrite <= 1'b0;
                        state      <= DONE_D;
                    end
                end
                I_BEAT: begin
                    if (mem_done) begin
                        bus.ireaddata[{beat, 5'd0} +: 32] <= bus.mreaddata;
                        bus.mread <= 1'b0;
                        state     <= (beat == LAST_BEAT) ? DONE_I : I_GAP;
                    end
                end
                I_GAP: begin
                    beat         <= beat + 2'd1;
                    bus.maddress <= i_word_addr(bus.iaddress, beat + 2'd1);
                    bus.mread    <= 1'b1;
                    seen_busy    <= 1'b0;
                    state        <= I_BEAT;
                end
                DONE_I: begin
                    last  <= OWN_I;
                    state <= IDLE;
                end
                DONE_D: begin
                    last  <= OWN_D;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: busy-protocol memory model, directed vector table,
// hand-written tie/starvation/reset sequences and a randomized phase.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int TIMEOUT = 400;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    arb_state_e dbg_state;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Memory model: busy from the first edge that sees a request, data valid at
    // completion edge number mem_lat counted from the issuing edge.
    logic [31:0] mem [512];
    logic [31:0] ref_mem [512];
    bit          mem_ready;
    int          mem_lat = 5;
    int          m_cnt = 0;
    logic [9:0]  obs_q [$];
    logic [9:0]  exp_q [$];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < 512; a++) mem[a] <= (a == 15) ? 32'hA5A5A5A5 : (32'hC0DE0000 | 32'(a));
            mem_ready     <= 1'b1;
            bus.mbusy     <= 1'b0;
            bus.mreaddata <= 32'd0;
            m_cnt         <= 0;
        end else if (!(bus.mread || bus.mwrite)) begin
            m_cnt     <= 0;
            bus.mbusy <= 1'b0;
        end else begin
            if (m_cnt == 0) obs_q.push_back({bus.mwrite, bus.maddress});
            m_cnt     <= m_cnt + 1;
            bus.mbusy <= (m_cnt + 1 < mem_lat - 1);
            if (m_cnt + 1 == mem_lat - 1) begin
                if (bus.mwrite) mem[bus.maddress] <= bus.mwritedata;
                else            bus.mreaddata     <= mem[bus.maddress];
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic check_order(input string name);
        int n;
        check({name, "_count"}, 128'(obs_q.size()), 128'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) check({name, "_access"}, 128'(obs_q[k]), 128'(exp_q[k]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic push_i(input logic [5:0] a);
        for (int b = 0; b < BEATS; b++) exp_q.push_back({1'b0, 9'(256 + 4 * int'(a) + b)});
    endtask

    function automatic logic [127:0] exp_block(input logic [5:0] a);
        logic [127:0] r;
        for (int b = 0; b < BEATS; b++) r[b*32 +: 32] = ref_mem[256 + 4 * int'(a) + b];
        return r;
    endfunction

    task automatic d_access(input logic wr, input logic [5:0] a, input logic [31:0] wd,
                            input bit keep, output logic [31:0] rd, output int edges);
        bus.dread = ~wr;
        bus.dwrite = wr;
        bus.daddress = a;
        bus.dwritedata = wd;
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (bus.dbusy && edges < TIMEOUT);
        check("d_done", 128'(bus.dbusy), 128'd0);
        rd = bus.dreaddata;
        if (!keep) begin
            bus.dread = 1'b0;
            bus.dwrite = 1'b0;
        end
    endtask

    task automatic i_access(input logic [5:0] a, input bit keep, output logic [127:0] rd,
                            output int edges);
        bus.iread = 1'b1;
        bus.iaddress = a;
        edges = 0;
        do begin
            @(negedge clk);
            edges++;
        end while (bus.ibusy && edges < TIMEOUT);
        check("i_done", 128'(bus.ibusy), 128'd0);
        rd = bus.ireaddata;
        if (!keep) bus.iread = 1'b0;
    endtask

    logic [31:0] last_dread;
    owner_e      model_last;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_dread = 32'd0;
        model_last = OWN_D;
        obs_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic         is_i;
        logic         wr;
        logic [5:0]   addr;
        logic [31:0]  wdata;
        int           lat;
        logic [127:0] exp_data;
    } vec_t;

    vec_t         vecs [7];
    logic [127:0] rd128, rd128b;
    logic [31:0]  rd32, rd32b;
    int           e1, e2, e3;
    int           mode, lat;
    logic [5:0]   ia, da;
    logic         wr;
    logic [31:0]  wd;
    bit           i_first;

    initial begin
        for (int a = 0; a < 512; a++) ref_mem[a] = (a == 15) ? 32'hA5A5A5A5 : (32'hC0DE0000 | 32'(a));
        bus.iread = 1'b0;
        bus.iaddress = 6'd0;
        bus.dread = 1'b0;
        bus.dwrite = 1'b0;
        bus.daddress = 6'd0;
        bus.dwritedata = 32'd0;
        last_dread = 32'd0;
        model_last = OWN_D;

        // Reset state and combinational busy during reset
        #12;
        check("rst_mread", 128'(bus.mread), 128'd0);
        check("rst_mwrite", 128'(bus.mwrite), 128'd0);
        check("rst_maddress", 128'(bus.maddress), 128'd0);
        check("rst_mwritedata", 128'(bus.mwritedata), 128'd0);
        check("rst_ireaddata", bus.ireaddata, 128'd0);
        check("rst_dreaddata", 128'(bus.dreaddata), 128'd0);
        check("rst_state", 128'(dbg_state), 128'(IDLE));
        bus.iread = 1'b1;
        bus.dread = 1'b1;
        #1;
        check("rst_ibusy", 128'(bus.ibusy), 128'd1);
        check("rst_dbusy", 128'(bus.dbusy), 128'd1);
        bus.iread = 1'b0;
        bus.dread = 1'b0;
        do_reset();

        vecs[0] = '{1'b0, 1'b0, 6'h0F, 32'h0, 5, 128'hA5A5A5A5};
        vecs[1] = '{1'b1, 1'b0, 6'h02, 32'h0, 3, 128'hC0DE010B_C0DE010A_C0DE0109_C0DE0108};
        vecs[2] = '{1'b0, 1'b1, 6'h3F, 32'hDEADBEEF, 4, 128'hA5A5A5A5};
        vecs[3] = '{1'b0, 1'b0, 6'h3F, 32'h0, 3, 128'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b0, 6'h05, 32'h0, 6, 128'hC0DE0005};
        vecs[5] = '{1'b1, 1'b0, 6'h3F, 32'h0, 4, 128'hC0DE01FF_C0DE01FE_C0DE01FD_C0DE01FC};
        vecs[6] = '{1'b1, 1'b0, 6'h00, 32'h0, 3, 128'hC0DE0103_C0DE0102_C0DE0101_C0DE0100};

        for (int v = 0; v < 7; v++) begin
            mem_lat = vecs[v].lat;
            if (vecs[v].is_i) begin
                i_access(vecs[v].addr, 1'b0, rd128, e1);
                check("vec_iblock", rd128, vecs[v].exp_data);
                check("vec_ilatency", 128'(e1), 128'(4 * vecs[v].lat + 4));
                push_i(vecs[v].addr);
            end else begin
                d_access(vecs[v].wr, vecs[v].addr, vecs[v].wdata, 1'b0, rd32, e1);
                check("vec_dword", 128'(rd32), vecs[v].exp_data);
                check("vec_dlatency", 128'(e1), 128'(vecs[v].lat + 1));
                exp_q.push_back({vecs[v].wr, 3'b000, vecs[v].addr});
                if (vecs[v].wr) ref_mem[vecs[v].addr] = vecs[v].wdata;
            end
            check_order("vec_order");
            @(negedge clk);
        end

        // Tie after reset: I first, then D; I re-requesting meets a waiting D, D first
        do_reset();
        mem_lat = 3;
        fork
            begin
                i_access(6'h01, 1'b1, rd128, e1);
                i_access(6'h03, 1'b0, rd128b, e2);
            end
            d_access(1'b1, 6'h10, 32'h12345678, 1'b0, rd32, e3);
        join
        ref_mem[16] = 32'h12345678;
        push_i(6'h01);
        exp_q.push_back({1'b1, 9'h010});
        push_i(6'h03);
        check_order("tie_order");
        check("tie_iblock1", rd128, exp_block(6'h01));
        check("tie_iblock2", rd128b, exp_block(6'h03));
        check("tie_ilatency", 128'(e1), 128'(4 * 3 + 4));
        check("tie_dlatency", 128'(e3), 128'((4 * 3 + 4) + 1 + (3 + 1)));
        @(negedge clk);

        // Back-to-back D requests while I waits: I goes between them
        mem_lat = 4;
        fork
            begin
                d_access(1'b0, 6'h0F, 32'h0, 1'b1, rd32, e1);
                d_access(1'b0, 6'h10, 32'h0, 1'b0, rd32b, e2);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                i_access(6'h07, 1'b0, rd128, e3);
            end
        join
        exp_q.push_back({1'b0, 9'h00F});
        push_i(6'h07);
        exp_q.push_back({1'b0, 9'h010});
        check_order("starve_order");
        check("starve_d1", 128'(rd32), 128'(ref_mem[15]));
        check("starve_d2", 128'(rd32b), 128'(ref_mem[16]));
        check("starve_iblock", rd128, exp_block(6'h07));
        @(negedge clk);

        // Reset during beat 2 of a refill, IREAD held through it
        mem_lat = 4;
        obs_q.delete();
        bus.iread = 1'b1;
        bus.iaddress = 6'h09;
        e1 = 0;
        while (obs_q.size() < 3 && e1 < TIMEOUT) begin
            @(negedge clk);
            e1++;
        end
        check("rst_mid_reached_beat2", 128'(obs_q.size()), 128'd3);
        @(negedge clk);
        check("rst_mid_mread_before", 128'(bus.mread), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_mread", 128'(bus.mread), 128'd0);
        check("rst_mid_ireaddata", bus.ireaddata, 128'd0);
        check("rst_mid_state", 128'(dbg_state), 128'(IDLE));
        check("rst_mid_ibusy", 128'(bus.ibusy), 128'd1);
        @(negedge clk);
        obs_q.delete();
        rst_n = 1'b1;
        last_dread = 32'd0;
        model_last = OWN_D;
        i_access(6'h09, 1'b0, rd128, e1);
        check("rst_mid_iblock", rd128, 128'hC0DE0127_C0DE0126_C0DE0125_C0DE0124);
        push_i(6'h09);
        check_order("rst_mid_order");
        @(negedge clk);

        // Randomized traffic against the arbitration and memory reference model
        do_reset();
        for (int it = 0; it < 25; it++) begin
            mode = $urandom_range(0, 2);
            lat = $urandom_range(3, 6);
            ia = 6'($urandom_range(0, 63));
            da = 6'($urandom_range(0, 63));
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            mem_lat = lat;
            if (mode == 0) begin
                i_access(ia, 1'b0, rd128, e1);
                check("rnd_iblock", rd128, exp_block(ia));
                check("rnd_ilatency", 128'(e1), 128'(4 * lat + 4));
                push_i(ia);
                model_last = OWN_I;
            end else if (mode == 1) begin
                d_access(wr, da, wd, 1'b0, rd32, e1);
                if (!wr) last_dread = ref_mem[da];
                check("rnd_dword", 128'(rd32), 128'(last_dread));
                check("rnd_dlatency", 128'(e1), 128'(lat + 1));
                exp_q.push_back({wr, 3'b000, da});
                if (wr) ref_mem[da] = wd;
                model_last = OWN_D;
            end else begin
                i_first = (model_last == OWN_D);
                fork
                    i_access(ia, 1'b0, rd128, e1);
                    d_access(wr, da, wd, 1'b0, rd32, e2);
                join
                if (!wr) last_dread = ref_mem[da];
                check("rnd_tie_iblock", rd128, exp_block(ia));
                check("rnd_tie_dword", 128'(rd32), 128'(last_dread));
                if (i_first) begin
                    push_i(ia);
                    exp_q.push_back({wr, 3'b000, da});
                    check("rnd_tie_ilatency", 128'(e1), 128'(4 * lat + 4));
                    check("rnd_tie_dlatency", 128'(e2), 128'(5 * lat + 6));
                    model_last = OWN_D;
                end else begin
                    exp_q.push_back({wr, 3'b000, da});
                    push_i(ia);
                    check("rnd_tie_dlatency", 128'(e2), 128'(lat + 1));
                    check("rnd_tie_ilatency", 128'(e1), 128'(5 * lat + 6));
                    model_last = OWN_I;
                end
                if (wr) ref_mem[da] = wd;
            end
            check_order("rnd_order");
            @(negedge clk);
        end

        // Every word written during the run must be in the memory model
        for (int a = 0; a < 64; a++) check("final_mem", 128'(mem[a]), 128'(ref_mem[a]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
